// File: rtl/i2s_loopback_top.sv
// I2S slave loopback self-test: port 0 transmits a counter pattern and checks it
// back through an external tx->rx loop, port 1 transmits an independent pattern.

module i2s_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         refclk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] ff [STAGES];

   always_ff @(posedge refclk) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) ff[i] <= '0;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
   end

   assign q = ff[STAGES-1];
endmodule

module i2s_tx #(
   parameter int WORD_BITS = 24
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 shift,
   input  logic                 load,
   input  logic [WORD_BITS-1:0] word,
   output logic                 tx
);
   logic [WORD_BITS-1:0] sh;

   // Zeros shift in behind the word, so the line idles low once the word is out.
   always_ff @(posedge refclk) begin
      if (!rst) begin
         sh <= '0;
         tx <= 1'b0;
      end else if (load) begin
         tx <= word[WORD_BITS-1];
         sh <= {word[WORD_BITS-2:0], 1'b0};
      end else if (shift) begin
         tx <= sh[WORD_BITS-1];
         sh <= {sh[WORD_BITS-2:0], 1'b0};
      end
   end
endmodule

// Checker FSM
//   state     | meaning
//   ST_WARMUP | discarding the first WARMUP_WORDS received words
//   ST_CHECK  | comparing each received word, counting good words
//   ST_PASS   | PASS_WORDS consecutive good words seen; terminal
//   ST_FAIL   | a checked word mismatched; terminal
module i2s_loopback_top #(
   parameter int WORD_BITS    = 24,
   parameter int SYNC_STAGES  = 2,
   parameter int WARMUP_WORDS = 4,
   parameter int PASS_WORDS   = 16
) (
   input  logic refclk,
   input  logic rst,
   input  logic i2s0_clk,
   input  logic i2s0_sync,
   output logic i2s0_tx,
   input  logic i2s0_rx,
   input  logic i2s1_clk,
   input  logic i2s1_sync,
   output logic i2s1_tx,
   output logic sim_success,
   output logic sim_done,
   output logic sim_report
);
   localparam int CW      = $clog2(WORD_BITS + 1);
   localparam int CNT_MAX = (WARMUP_WORDS > PASS_WORDS) ? WARMUP_WORDS : PASS_WORDS;
   localparam int NW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {ST_WARMUP, ST_CHECK, ST_PASS, ST_FAIL} state_t;
   state_t state, state_nxt;

   logic [2:0] in0_s;
   logic [1:0] in1_s;
   logic bclk0_s, ws0_s, rx0_s, bclk1_s, ws1_s;
   logic bclk0_d, ws0_prev, bclk1_d, ws1_prev;
   logic fall0, rise0, load0, fall1, load1;

   logic [WORD_BITS-1:0] p0, word0, exp0, rx_sh, rx_next, word1;
   logic [11:0]          p1, p1_nxt;
   logic [CW-1:0]        rx_cnt;
   logic                 word_done, word_ok;
   logic [NW-1:0]        cnt;
   logic                 cnt_dec, cnt_load, report_nxt;

   i2s_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync0 (
      .refclk (refclk),
      .rst    (rst),
      .d      ({i2s0_clk, i2s0_sync, i2s0_rx}),
      .q      (in0_s)
   );

   i2s_sync #(.W(2), .STAGES(SYNC_STAGES)) u_sync1 (
      .refclk (refclk),
      .rst    (rst),
      .d      ({i2s1_clk, i2s1_sync}),
      .q      (in1_s)
   );

   assign bclk0_s = in0_s[2];
   assign ws0_s   = in0_s[1];
   assign rx0_s   = in0_s[0];
   assign bclk1_s = in1_s[1];
   assign ws1_s   = in1_s[0];

   assign fall0 = bclk0_d & ~bclk0_s;
   assign rise0 = ~bclk0_d & bclk0_s;
   assign fall1 = bclk1_d & ~bclk1_s;
   assign load0 = fall0 & (ws0_s != ws0_prev);
   assign load1 = fall1 & (ws1_s != ws1_prev);

   // A frame starts on the right->left change; the left word carries the
   // incremented count so both words of one frame share the same count.
   assign word0  = ws0_s ? ~p0 : p0 + WORD_BITS'(1);
   assign p1_nxt = p1 + 12'd1;
   assign word1  = ws1_s ? {12'hA5A, p1} : {p1_nxt, 12'h5A5};

   always_ff @(posedge refclk) begin
      if (!rst) begin
         bclk0_d  <= 1'b0;
         bclk1_d  <= 1'b0;
         ws0_prev <= 1'b0;
         ws1_prev <= 1'b0;
         p0       <= '0;
         p1       <= '0;
         exp0     <= '0;
      end else begin
         bclk0_d <= bclk0_s;
         bclk1_d <= bclk1_s;
         if (fall0) ws0_prev <= ws0_s;
         if (fall1) ws1_prev <= ws1_s;
         if (load0) exp0 <= word0;
         if (load0 && !ws0_s) p0 <= p0 + WORD_BITS'(1);
         if (load1 && !ws1_s) p1 <= p1_nxt;
      end
   end

   i2s_tx #(.WORD_BITS(WORD_BITS)) u_tx0 (
      .refclk (refclk),
      .rst    (rst),
      .shift  (fall0),
      .load   (load0),
      .word   (word0),
      .tx     (i2s0_tx)
   );

   i2s_tx #(.WORD_BITS(WORD_BITS)) u_tx1 (
      .refclk (refclk),
      .rst    (rst),
      .shift  (fall1),
      .load   (load1),
      .word   (word1),
      .tx     (i2s1_tx)
   );

   // Bit down-counter reloads on every sync change; a slot that ends early never
   // reaches the terminal count, so its partial word is dropped.
   assign rx_next   = {rx_sh[WORD_BITS-2:0], rx0_s};
   assign word_done = rise0 && (rx_cnt == CW'(1));
   assign word_ok   = (rx_next == exp0);

   always_ff @(posedge refclk) begin
      if (!rst) begin
         rx_sh  <= '0;
         rx_cnt <= '0;
      end else if (load0) begin
         rx_cnt <= CW'(WORD_BITS);
      end else if (rise0 && rx_cnt != '0) begin
         rx_sh  <= rx_next;
         rx_cnt <= rx_cnt - CW'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_dec    = 1'b0;
      cnt_load   = 1'b0;
      report_nxt = 1'b0;
      case (state)
         ST_WARMUP: begin
            if (word_done) begin
               if (cnt == NW'(1)) begin
                  state_nxt = ST_CHECK;
                  cnt_load  = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         ST_CHECK: begin
            if (word_done) begin
               report_nxt = 1'b1;
               if (!word_ok) begin
                  state_nxt = ST_FAIL;
               end else if (cnt == NW'(1)) begin
                  state_nxt = ST_PASS;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge refclk) begin
      if (!rst) begin
         state      <= ST_WARMUP;
         cnt        <= NW'(WARMUP_WORDS);
         sim_report <= 1'b0;
      end else begin
         state      <= state_nxt;
         sim_report <= report_nxt;
         if (cnt_load)     cnt <= NW'(PASS_WORDS);
         else if (cnt_dec) cnt <= cnt - NW'(1);
      end
   end

   assign sim_done    = (state == ST_PASS) || (state == ST_FAIL);
   assign sim_success = (state == ST_PASS);
endmodule

// File: tb/tb_i2s_loopback_top.sv
// Bench for i2s_loopback_top: drives both slave links, loops port 0 back, and
// compares checker outcome and decoded TX patterns with a slot-level model.

module tb_i2s_loopback_top;
   localparam int WB    = 24;
   localparam int WARM  = 4;
   localparam int PASSN = 16;
   localparam int H0    = 651;
   localparam int H1    = 600;

   typedef struct {
      logic        s;
      logic [23:0] w;
      int          n;
   } slot_t;

   logic refclk    = 1'b0;
   logic rst       = 1'b0;
   logic i2s0_clk  = 1'b1;
   logic i2s0_sync = 1'b0;
   logic i2s1_clk  = 1'b1;
   logic i2s1_sync = 1'b0;
   logic loop_en   = 1'b1;
   logic i2s0_tx, i2s1_tx, i2s0_rx;
   logic sim_success, sim_done, sim_report;

   int n_cmp   = 0;
   int n_bad   = 0;
   int rep_cnt = 0;
   int b0, b1;
   int lens[$];

   slot_t q0[$];
   slot_t q1[$];
   logic        d0_s = 1'b0, d1_s = 1'b0;
   logic [23:0] d0_w = '0,   d1_w = '0;
   int          d0_n = 0,    d1_n = 0;

   assign i2s0_rx = loop_en ? i2s0_tx : 1'b0;

   i2s_loopback_top dut (
      .refclk      (refclk),
      .rst         (rst),
      .i2s0_clk    (i2s0_clk),
      .i2s0_sync   (i2s0_sync),
      .i2s0_tx     (i2s0_tx),
      .i2s0_rx     (i2s0_rx),
      .i2s1_clk    (i2s1_clk),
      .i2s1_sync   (i2s1_sync),
      .i2s1_tx     (i2s1_tx),
      .sim_success (sim_success),
      .sim_done    (sim_done),
      .sim_report  (sim_report)
   );

   always #42 refclk = ~refclk;

   always @(negedge refclk) if (sim_report === 1'b1) rep_cnt++;

   // Slot decoders: one entry per sync slot, first WB bits taken MSB-first.
   always @(posedge i2s0_clk) begin
      if (i2s0_sync != d0_s) begin
         if (d0_n > 0) q0.push_back('{d0_s, d0_w, d0_n});
         d0_s = i2s0_sync;
         d0_w = '0;
         d0_n = 0;
      end
      if (d0_n < WB) begin
         d0_w = {d0_w[22:0], i2s0_tx};
         d0_n++;
      end
   end

   always @(posedge i2s1_clk) begin
      if (i2s1_sync != d1_s) begin
         if (d1_n > 0) q1.push_back('{d1_s, d1_w, d1_n});
         d1_s = i2s1_sync;
         d1_w = '0;
         d1_n = 0;
      end
      if (d1_n < WB) begin
         d1_w = {d1_w[22:0], i2s1_tx};
         d1_n++;
      end
   end

   initial begin
      @(posedge refclk);
      #10;
      forever begin
         i2s1_clk  = 1'b0;
         i2s1_sync = ~i2s1_sync;
         #H1 i2s1_clk = 1'b1;
         #H1;
         repeat (WB - 1) begin
            i2s1_clk = 1'b0;
            #H1 i2s1_clk = 1'b1;
            #H1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic gen0(input int len);
      i2s0_clk  = 1'b0;
      i2s0_sync = ~i2s0_sync;
      #H0 i2s0_clk = 1'b1;
      #H0;
      repeat (len - 1) begin
         i2s0_clk = 1'b0;
         #H0 i2s0_clk = 1'b1;
         #H0;
      end
   endtask

   // Slot-level checker model: only full slots yield words.
   function automatic void predict(input bit loop, output bit done, output bit succ,
                                   output int reps);
      int words = 0;
      int good  = 0;
      done = 1'b0;
      succ = 1'b0;
      reps = 0;
      foreach (lens[i]) begin
         if (lens[i] < WB || done) continue;
         if (words < WARM) begin
            words++;
         end else begin
            reps++;
            if (!loop) begin
               done = 1'b1;
            end else begin
               good++;
               if (good == PASSN) begin
                  done = 1'b1;
                  succ = 1'b1;
               end
            end
         end
      end
   endfunction

   task automatic do_reset();
      @(negedge refclk);
      rst       = 1'b0;
      i2s0_clk  = 1'b1;
      i2s0_sync = 1'b0;
      repeat (13) @(negedge refclk);
      check("rst_done", sim_done, 0);
      check("rst_success", sim_success, 0);
      check("rst_report", sim_report, 0);
      check("rst_tx0", i2s0_tx, 0);
      check("rst_tx1", i2s1_tx, 0);
      rst = 1'b1;
   endtask

   task automatic run_test(input bit loop, input int short_pos, input int short_len,
                           input int n_full);
      bit   e_done, e_succ;
      int   e_rep, rep0, total;
      logic h_done, h_succ;
      total = n_full + ((short_pos >= 0) ? 1 : 0);
      lens.delete();
      for (int i = 0; i < total; i++) lens.push_back((i == short_pos) ? short_len : WB);
      predict(loop, e_done, e_succ, e_rep);
      loop_en = loop;
      do_reset();
      repeat ($urandom_range(0, 20)) @(posedge refclk);
      @(posedge refclk);
      #10;
      rep0 = rep_cnt;
      b0   = q0.size();
      b1   = q1.size();
      foreach (lens[i]) gen0(lens[i]);
      repeat (30) @(negedge refclk);
      check("done", sim_done, e_done);
      check("success", sim_success, e_succ);
      check("reports", rep_cnt - rep0, e_rep);
      h_done = sim_done;
      h_succ = sim_success;
      repeat (200) @(negedge refclk);
      check("hold_done", sim_done, e_done);
      check("hold_success", sim_success, e_succ);
      check("hold_reports", rep_cnt - rep0, e_rep);
      check("hold_stable", {h_done, h_succ}, {sim_done, sim_success});
   endtask

   task automatic check_p0(input int from);
      int          pairs = 0;
      logic [23:0] nxt;
      for (int i = from; i + 1 < q0.size(); i++) begin
         if (q0[i].n != WB || q0[i+1].n != WB) continue;
         pairs++;
         if (!q0[i].s && q0[i+1].s) begin
            check("p0_right_inv", {8'h0, q0[i+1].w}, {8'h0, ~q0[i].w});
         end else if (q0[i].s && !q0[i+1].s) begin
            nxt = ~q0[i].w + 24'd1;
            check("p0_left_next", {8'h0, q0[i+1].w}, {8'h0, nxt});
         end else begin
            check("p0_sync_alt", q0[i+1].s, ~q0[i].s);
         end
      end
      check("p0_pairs_seen", pairs >= 10, 1);
   endtask

   task automatic check_p1(input int from);
      int          pairs = 0;
      logic [11:0] nxt;
      for (int i = from; i + 1 < q1.size(); i++) begin
         if (q1[i].n != WB || q1[i+1].n != WB) continue;
         pairs++;
         if (!q1[i].s && q1[i+1].s) begin
            check("p1_left_lo", q1[i].w[11:0], 12'h5A5);
            check("p1_right_hi", q1[i+1].w[23:12], 12'hA5A);
            check("p1_frame_cnt", q1[i+1].w[11:0], q1[i].w[23:12]);
         end else if (q1[i].s && !q1[i+1].s) begin
            nxt = q1[i].w[11:0] + 12'd1;
            check("p1_next_frame", q1[i+1].w[23:12], nxt);
         end else begin
            check("p1_sync_alt", q1[i+1].s, ~q1[i].s);
         end
      end
      check("p1_pairs_seen", pairs >= 10, 1);
   endtask

   task automatic run_midrun();
      int rep_mid = 0;
      loop_en = 1'b1;
      do_reset();
      @(posedge refclk);
      #10;
      fork
         begin
            for (int i = 0; i < WARM + PASSN + 26; i++) gen0(WB);
         end
         begin
            int k = 0;
            while (sim_done !== 1'b1 && k < 12000) begin
               @(negedge refclk);
               k++;
            end
            check("mid_pass_before_rst", sim_success, 1);
            repeat ($urandom_range(10, 400)) @(negedge refclk);
            rst = 1'b0;
            repeat (13) @(negedge refclk);
            check("mid_rst_done", sim_done, 0);
            check("mid_rst_success", sim_success, 0);
            check("mid_rst_report", sim_report, 0);
            check("mid_rst_tx0", i2s0_tx, 0);
            check("mid_rst_tx1", i2s1_tx, 0);
            rst     = 1'b1;
            rep_mid = rep_cnt;
         end
      join
      repeat (30) @(negedge refclk);
      check("mid_repass_done", sim_done, 1);
      check("mid_repass_success", sim_success, 1);
      check("mid_repass_reports", rep_cnt - rep_mid, PASSN);
   endtask

   initial begin
      int n;
      run_test(1'b1, -1, 0, WARM + PASSN + int'($urandom_range(0, 3)));
      check_p0(b0 + 1);
      check_p1(b1 + 3);
      run_test(1'b0, -1, 0, WARM + 1 + int'($urandom_range(0, 2)));
      n = WARM + PASSN + int'($urandom_range(0, 2));
      run_test(1'b1, int'($urandom_range(0, n)), 20, n);
      run_test(1'b1, int'($urandom_range(0, n)), int'($urandom_range(1, WB - 1)), n);
      run_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
